pc_fetch_ctrl: RTL

Fetch-stage PC sequencer for the five-stage MIPS pipeline. It consumes the redirect request that the fetch-stage jump controller produces (jump flag, jump target, jr stall) and the branch redirect from decode. It owns the architectural fetch PC and produces `is_jr_D`, the registered "jr/jalr now in decode" flag that the jump controller needs to release its stall. It also keeps two free-running performance counters.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/perf_counter.sv | 16 +
 rtl/pc_fetch_ctrl.sv | 97 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch-stage PC sequencer and its helpers.
package cpu_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
   localparam logic [31:0] PC_INC           = 32'd4;

   typedef enum logic {
      RUN     = 1'b0,
      JR_WAIT = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/perf_counter.sv
// 32-bit free-running event counter; wraps silently, synchronous reset.
module perf_counter (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   output logic [31:0] count
);

   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (inc)
         count <= count + 32'd1;
   end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch PC sequencer: selects the next PC from branch/jump/jr requests and
// tracks a one-cycle jr wait so the jump controller can release its stall.
module pc_fetch_ctrl
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_D,
   input  logic        branch_D,
   input  logic [31:0] pc_branch_D,
   input  logic        jump_F,
   input  logic [31:0] pc_jump_F,
   input  logic        jump_stall,
   input  logic        is_jr_F,
   output logic [31:0] pc_F,
   output logic [31:0] pc_plus_F,
   output logic        is_jr_D,
   output logic [31:0] redirect_cnt,
   output logic [31:0] stall_cnt
);

   fetch_state_t state, state_nxt;
   logic [31:0]  pc_nxt;
   logic         jr_nxt;
   logic         redirect_inc;
   logic         stall_inc;
   logic         unused_is_jr_F;

   // is_jr_F is already folded into jump_stall by the jump controller.
   assign unused_is_jr_F = is_jr_F;

   assign pc_plus_F = pc_F + PC_INC;

   always_comb begin
      pc_nxt       = pc_plus_F;
      state_nxt    = state;
      jr_nxt       = is_jr_D;
      redirect_inc = 1'b0;
      stall_inc    = 1'b0;
      if (stall_D) begin
         pc_nxt    = pc_F;
         stall_inc = 1'b1;
      end else if (branch_D) begin
         pc_nxt       = pc_branch_D;
         state_nxt    = RUN;
         jr_nxt       = 1'b0;
         redirect_inc = 1'b1;
      end else if (state == RUN) begin
         if (jump_stall) begin
            pc_nxt    = pc_F;
            state_nxt = JR_WAIT;
            jr_nxt    = 1'b1;
            stall_inc = 1'b1;
         end else if (jump_F) begin
            pc_nxt       = pc_jump_F;
            redirect_inc = 1'b1;
         end
      end else begin
         // JR_WAIT always returns to RUN; jump_stall is deliberately ignored here.
         state_nxt = RUN;
         jr_nxt    = 1'b0;
         if (jump_F) begin
            pc_nxt       = pc_jump_F;
            redirect_inc = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= RUN;
         pc_F    <= RESET_PC;
         is_jr_D <= 1'b0;
      end else begin
         state   <= state_nxt;
         pc_F    <= pc_nxt;
         is_jr_D <= jr_nxt;
      end
   end

   perf_counter u_redirect_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (redirect_inc),
      .count (redirect_cnt)
   );

   perf_counter u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_inc),
      .count (stall_cnt)
   );

endmodule
